aes_key_expand_seq: RTL and testbench

Sequential AES key-schedule engine. It is the parametrised successor to the combinational AES-128 KeyGen function.
- Supports AES-128, AES-192 and AES-256, selected at run time.
- Produces one 32-bit schedule word per cycle.
- Streams complete 128-bit round keys over a valid/ready interface to the round datapath.
- Byte substitution uses AES_Operations::ByteSub; no local S-box table.

---
 rtl/AES_Operations.sv | 32 +++
 rtl/aes_key_expand_seq.sv | 183 ++++++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/AES_Operations.sv
// Shared AES byte-level helpers used by the key schedule and round datapath.
// ByteSub computes the S-box arithmetically: GF(2^8) inverse (x^254) then the affine map.
// Pure functions, no state; callers decide how the logic is pipelined.
package AES_Operations;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] ByteSub(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      // r = a^(2+4+...+128) = a^254, the multiplicative inverse (0 maps to 0)
      r = 8'h01;
      p = a;
      for (int k = 0; k < 7; k++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
               ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key schedule: one 32-bit word per cycle, 128-bit round keys out.
// Latency: word j at start+1+j, round r valid at start+5+4r when the consumer never stalls.
// Backpressure: rk_valid/rk_ready; a full assembly buffer with a blocked output freezes generation.
module aes_key_expand_seq #(
   parameter int MAX_NK = 8,
   parameter int KEY_W  = 32*MAX_NK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       key_len,
   input  logic [KEY_W-1:0] key_in,
   output logic             busy,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic [3:0]       rk_idx,
   output logic [127:0]     rk_data,
   output logic             done,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_t;

   state_t           state, state_nxt;
   logic [KEY_W-1:0] key_r;        // remaining key words, next one at the top
   logic [3:0]       nk, nr;
   logic [5:0]       nw;
   logic [5:0]       word_i;
   logic [2:0]       mod_cnt;      // word_i mod nk, kept incrementally
   logic [7:0]       rcon;
   logic [31:0]      win [8];      // win[7] = w[i-1] ... win[0] = w[i-8]
   logic [31:0]      asm_buf [4];
   logic [2:0]       asm_cnt;
   logic [3:0]       rnd;

   logic [3:0]       nk_sel;
   logic             legal, accept, bad, gen, xfer, last_hs, full, out_free;
   logic [31:0]      t, w_back, new_word;

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {AES_Operations::ByteSub(w[31:24]), AES_Operations::ByteSub(w[23:16]),
              AES_Operations::ByteSub(w[15:8]),  AES_Operations::ByteSub(w[7:0])};
   endfunction

   assign nw       = {nr + 4'd1, 2'b00};
   assign full     = (asm_cnt == 3'd4);
   assign out_free = !rk_valid || rk_ready;
   assign busy     = (state != IDLE);

   // Decode key length into Nk; anything beyond the synthesised window size is illegal
   always_comb begin
      nk_sel = 4'd0;
      case (key_len)
         2'd0:    nk_sel = 4'd4;
         2'd1:    nk_sel = 4'd6;
         2'd2:    nk_sel = 4'd8;
         default: nk_sel = 4'd0;
      endcase
      legal = (nk_sel != 4'd0) && (nk_sel <= 4'(MAX_NK));
   end

   // Next schedule word: key words while loading, recurrence w[i-Nk] ^ t while expanding
   always_comb begin
      t = win[7];
      if (mod_cnt == 3'd0)
         t = sub_word({win[7][23:0], win[7][31:24]}) ^ {rcon, 24'h0};
      else if (nk == 4'd8 && mod_cnt == 3'd4)
         t = sub_word(win[7]);
      case (nk)
         4'd6:    w_back = win[2];
         4'd8:    w_back = win[0];
         default: w_back = win[4];
      endcase
      new_word = (state == LOAD) ? key_r[KEY_W-1 -: 32] : (w_back ^ t);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state plus per-cycle strobes: generate a word, move buffer to output, final handshake
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      bad       = 1'b0;
      gen       = 1'b0;
      xfer      = 1'b0;
      last_hs   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (legal) begin
                  accept    = 1'b1;
                  state_nxt = LOAD;
               end else begin
                  bad = 1'b1;
               end
            end
         end
         LOAD: begin
            xfer = full && out_free;
            gen  = !full || out_free;
            if (gen && word_i == ({2'b00, nk} - 6'd1)) state_nxt = EXPAND;
         end
         EXPAND: begin
            xfer = full && out_free;
            gen  = !full || out_free;
            if (gen && word_i == (nw - 6'd1)) state_nxt = DRAIN;
         end
         DRAIN: begin
            xfer    = full && out_free;
            last_hs = rk_valid && rk_ready && (rk_idx == nr);
            if (last_hs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Schedule datapath: window, counters, assembly buffer and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         key_r    <= '0;
         nk       <= 4'd0;
         nr       <= 4'd0;
         word_i   <= 6'd0;
         mod_cnt  <= 3'd0;
         rcon     <= 8'h00;
         asm_cnt  <= 3'd0;
         rnd      <= 4'd0;
         rk_valid <= 1'b0;
         rk_idx   <= 4'd0;
         rk_data  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         for (int k = 0; k < 8; k++) win[k] <= 32'h0;
         for (int k = 0; k < 4; k++) asm_buf[k] <= 32'h0;
      end else begin
         err  <= bad;
         done <= last_hs;
         if (accept) begin
            key_r   <= key_in;
            nk      <= nk_sel;
            nr      <= nk_sel + 4'd6;
            word_i  <= 6'd0;
            mod_cnt <= 3'd0;
            rcon    <= 8'h01;
            asm_cnt <= 3'd0;
            rnd     <= 4'd0;
         end
         if (gen) begin
            for (int k = 0; k < 7; k++) win[k] <= win[k+1];
            win[7]  <= new_word;
            word_i  <= word_i + 6'd1;
            mod_cnt <= ({1'b0, mod_cnt} == nk - 4'd1) ? 3'd0 : mod_cnt + 3'd1;
            if (state == EXPAND && mod_cnt == 3'd0)
               rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (state == LOAD)
               key_r <= key_r << 32;
            // a full buffer only generates when it is emptying this same cycle
            if (full) begin
               asm_buf[0] <= new_word;
               asm_cnt    <= 3'd1;
            end else begin
               asm_buf[asm_cnt[1:0]] <= new_word;
               asm_cnt               <= asm_cnt + 3'd1;
            end
         end else if (xfer) begin
            asm_cnt <= 3'd0;
         end
         if (xfer) begin
            rk_valid <= 1'b1;
            rk_data  <= {asm_buf[0], asm_buf[1], asm_buf[2], asm_buf[3]};
            rk_idx   <= rnd;
            rnd      <= rnd + 4'd1;
         end else if (rk_ready) begin
            rk_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
module tb_aes_key_expand_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   key_len;
   logic [255:0] key_in;
   logic         busy, rk_valid, rk_ready, done, err;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;

   aes_key_expand_seq #(.MAX_NK(8)) dut (
      .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
      .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_idx(rk_idx),
      .rk_data(rk_data), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int t_start = 0;
   int hs_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int err_cnt = 0;
   int hs_cyc [16];
   logic done_busy = 1'b0;
   logic mon_en = 1'b0;
   logic prev_stall = 1'b0;
   logic [3:0]   p_idx;
   logic [127:0] p_data;
   logic [131:0] exp_q [$];
   logic [7:0]   sbox [256];

   localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [191:0] KEY192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] RK128 [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Independent S-box: walk the multiplicative group with generator 3 and its inverse
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   task automatic push_128();
      for (int r = 0; r < 11; r++) exp_q.push_back({4'(r), RK128[r]});
   endtask

   // Reference key schedule over a full word array; final round taken from the published vector
   task automatic push_model(input int nk, input logic [255:0] key, input logic [127:0] last_rk);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk == 8 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++) begin
         if (r == nr) exp_q.push_back({4'(r), last_rk});
         else         exp_q.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
      end
   endtask

   // Monitor: pop and compare on each handshake, check hold-during-stall, count done/err pulses
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (rk_valid && rk_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_rk: idx %0d data %h with nothing expected", rk_idx, rk_data);
            end else begin
               logic [131:0] e;
               e = exp_q.pop_front();
               if ({rk_idx, rk_data} !== e) begin
                  fails++;
                  $display("FAIL round_key: got idx %0d %h expected idx %0d %h",
                           rk_idx, rk_data, e[131:128], e[127:0]);
               end
            end
            hs_cyc[rk_idx] = cyc;
            hs_cnt++;
         end
         if (prev_stall) begin
            tests++;
            if (!rk_valid || rk_idx !== p_idx || rk_data !== p_data) begin
               fails++;
               $display("FAIL stall_hold: got v%0b idx %0d %h expected v1 idx %0d %h",
                        rk_valid, rk_idx, rk_data, p_idx, p_data);
            end
         end
         prev_stall = rk_valid && !rk_ready;
         p_idx      = rk_idx;
         p_data     = rk_data;
         if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = busy;
         end
         if (err) err_cnt++;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic run(input logic [1:0] kl, input logic [255:0] key, input bit rnd_rdy, input bit mid);
      int d0, e0, n;
      d0 = done_cnt;
      e0 = err_cnt;
      @(posedge clk); #1;
      key_len = kl;
      key_in  = key;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      t_start = cyc;
      key_in  = '0;
      n = 0;
      while (done_cnt == d0 && n < 4000) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) chk("busy_during_run", 256'(busy), 256'(1));
         if (rnd_rdy)
            rk_ready = ((n >= 8 && n < 28) || (n >= 90 && n < 110)) ? 1'b0 : 1'($urandom_range(0, 1));
         start = mid && (n == 20);
         if (start) begin
            key_len = 2'd1;
            key_in  = {256{1'b1}};
         end
      end
      start    = 1'b0;
      rk_ready = 1'b1;
      chk("done_seen", 256'(done_cnt - d0), 256'(1));
      chk("queue_drained", 256'(exp_q.size()), 256'(0));
      chk("no_err_in_run", 256'(err_cnt - e0), 256'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      int d0, h0, n;
      build_sbox();
      rst      = 1'b1;
      start    = 1'b0;
      key_len  = 2'd0;
      key_in   = '0;
      rk_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 256'({rk_valid, busy, done, err, rk_idx, rk_data}), 256'(0));
      rst    = 1'b0;
      mon_en = 1'b1;

      // AES-128, consumer always ready, latency checks; low key bits carry junk
      push_128();
      run(2'd0, {KEY128, 128'hdeadbeef_cafef00d_01234567_89abcdef}, 1'b0, 1'b0);
      chk("round1_cycle", 256'(hs_cyc[1]), 256'(t_start + 9));
      chk("round10_cycle", 256'(hs_cyc[10]), 256'(t_start + 45));
      chk("done_cycle", 256'(done_cyc), 256'(t_start + 46));
      chk("busy_low_at_done", 256'(done_busy), 256'(0));

      // AES-192 with an ignored start issued mid-run
      push_model(6, {KEY192, 64'h0}, 128'he98ba06f448c773c8ecc720401002202);
      run(2'd1, {KEY192, 64'h0}, 1'b0, 1'b1);

      // AES-256, exercises the mid-block SubWord
      push_model(8, KEY256, 128'hfe4890d1e6188d0b046df344706c631e);
      run(2'd2, KEY256, 1'b0, 1'b0);

      // AES-128 under random backpressure with two long stalls
      push_128();
      run(2'd0, {KEY128, 128'h0}, 1'b1, 1'b0);

      // Illegal key length
      @(posedge clk); #1;
      key_len = 2'd3;
      key_in  = KEY256;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("err_pulse", 256'(err), 256'(1));
      chk("busy_after_bad_len", 256'(busy), 256'(0));
      @(posedge clk); #1;
      chk("err_one_cycle", 256'(err), 256'(0));
      chk("still_idle", 256'(busy), 256'(0));

      // Reset after the round 3 handshake, then a fresh run
      push_128();
      d0 = done_cnt;
      h0 = hs_cnt;
      @(posedge clk); #1;
      key_len = 2'd0;
      key_in  = {KEY128, 128'h0};
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (hs_cnt - h0 < 4 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("four_rounds_before_rst", 256'(hs_cnt - h0), 256'(4));
      mon_en = 1'b0;
      rst    = 1'b1;
      @(posedge clk); #1;
      chk("outputs_after_rst", 256'({rk_valid, busy, done, err, rk_idx, rk_data}), 256'(0));
      rst = 1'b0;
      exp_q.delete();
      mon_en = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("no_done_after_rst", 256'(done_cnt - d0), 256'(0));
      push_128();
      run(2'd0, {KEY128, 128'h0}, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
